ttt_game_ctrl_n: RTL

Parametrised N×N tic-tac-toe game controller. It owns the board register, validates player moves, and runs a per-turn countdown. On timeout it places a pseudo-random move for the current player, then checks for a win or tie and alternates turns. It sits between the input decoder (move requests) and the display renderer (board/winner outputs).

---
 rtl/ttt_pkg.sv | 35 +++
 rtl/ttt_line_checker.sv | 34 +++
 rtl/ttt_game_ctrl_n.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
package ttt_pkg;

  // Contents of one board cell; 2'b11 is never written.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10
  } cell_t;

  // Controller states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_RANDOM = 3'd2,
    S_CHECK  = 3'd3,
    S_SWITCH = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Winner codes reported on the winner output.
  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_X    = 2'b01;
  localparam logic [1:0] W_O    = 2'b10;
  localparam logic [1:0] W_TIE  = 2'b11;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One LFSR step: shift left, feed the tap parity into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ttt_line_checker.sv
// Combinational win detector: is any full row, column or diagonal owned by `player`?
module ttt_line_checker #(
  parameter int N = 3
) (
  input  logic [2*N*N-1:0] board,
  input  logic [1:0]       player,
  output logic             win
);

  logic [N-1:0] row_win;
  logic [N-1:0] col_win;
  logic [N-1:0] diag_hit;
  logic [N-1:0] anti_hit;

  genvar r, c;

  // Each row / column is a win when all N of its cells hold the player code.
  for (r = 0; r < N; r++) begin : g_line
    logic [N-1:0] row_hit;
    logic [N-1:0] col_hit;
    for (c = 0; c < N; c++) begin : g_cell
      assign row_hit[c] = (board[2*(r*N+c) +: 2] == player);
      assign col_hit[c] = (board[2*(c*N+r) +: 2] == player);
    end
    assign row_win[r] = &row_hit;
    assign col_win[r] = &col_hit;
    // Main diagonal cell (r,r) and anti-diagonal cell (r,N-1-r).
    assign diag_hit[r] = (board[2*(r*N+r) +: 2] == player);
    assign anti_hit[r] = (board[2*(r*N+(N-1-r)) +: 2] == player);
  end

  assign win = (|row_win) | (|col_win) | (&diag_hit) | (&anti_hit);

endmodule

// File: rtl/ttt_game_ctrl_n.sv
// N x N tic-tac-toe controller: board register, move validation, per-turn
// countdown with a pseudo-random fallback move, and win/tie detection.
//
// Handshake: move_ready is high exactly while a player may move; a request
// is taken on any rising edge where move_valid && move_ready. The request is
// either written (redraw pulses next cycle) or refused (move_reject pulses
// next cycle); there is no back-pressure beyond move_ready.
module ttt_game_ctrl_n
  import ttt_pkg::*;
#(
  parameter int          N           = 3,
  parameter int          TURN_CYCLES = 250000000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int         NC          = N * N,
  localparam int         PW          = $clog2(NC),
  localparam int         TW          = $clog2(TURN_CYCLES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            move_valid,
  input  logic [PW-1:0]   move_pos,
  output logic            move_ready,
  output logic            move_reject,
  output logic            cur_player,
  output logic [2*NC-1:0] board,
  output logic [TW-1:0]   time_left,
  output logic            timeout_move,
  output logic            redraw,
  output logic            game_over,
  output logic [1:0]      winner,
  output state_t          dbg_state
);

  localparam int            CW       = $clog2(NC + 1);
  localparam logic [PW:0]   NC_EXT   = (PW + 1)'(NC);
  localparam logic [PW-1:0] LAST_IDX = PW'(NC - 1);
  localparam logic [TW-1:0] TURN_MAX = TW'(TURN_CYCLES - 1);

  state_t            state_q, state_d;
  logic [2*NC-1:0]   board_q, board_d;
  logic              cur_player_q, cur_player_d;
  logic [TW-1:0]     time_left_q, time_left_d;
  logic [1:0]        winner_q, winner_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     scan_q, scan_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              reject_q, reject_d;
  logic              tmove_q, tmove_d;
  logic              redraw_q, redraw_d;

  logic [1:0]        player_code;
  logic [1:0]        pos_cell;
  logic [1:0]        scan_cell;
  logic              pos_in_range;
  logic [PW-1:0]     seed_idx;
  logic [PW-1:0]     scan_next;
  logic              wr_en;
  logic [PW-1:0]     wr_idx;
  logic              win;

  assign player_code  = cur_player_q ? O : X;
  assign pos_in_range = ({1'b0, move_pos} < NC_EXT);
  assign seed_idx     = ({1'b0, lfsr_q[PW-1:0]} < NC_EXT) ? lfsr_q[PW-1:0] : '0;
  assign scan_next    = (scan_q == LAST_IDX) ? '0 : scan_q + PW'(1);

  // Line check for the player who just moved, on the already-updated board.
  ttt_line_checker #(.N(N)) u_line_checker (
    .board  (board_q),
    .player (player_code),
    .win    (win)
  );

  // Look up the cell addressed by the incoming request (empty if out of range).
  always_comb begin
    pos_cell = EMPTY;
    for (int i = 0; i < NC; i++) begin
      if (PW'(i) == move_pos) pos_cell = board_q[2*i +: 2];
    end
  end

  // Look up the cell currently examined by the random-move scan.
  always_comb begin
    scan_cell = EMPTY;
    for (int i = 0; i < NC; i++) begin
      if (PW'(i) == scan_q) scan_cell = board_q[2*i +: 2];
    end
  end

  // Next-state, board update, timer and pulse generation.
  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    cur_player_d = cur_player_q;
    time_left_d  = time_left_q;
    winner_d     = winner_q;
    count_d      = count_q;
    scan_d       = scan_q;
    lfsr_d       = lfsr_next(lfsr_q);
    reject_d     = 1'b0;
    tmove_d      = 1'b0;
    redraw_d     = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = move_pos;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_PLAY;
          board_d      = '0;
          cur_player_d = 1'b0;
          winner_d     = W_NONE;
          count_d      = '0;
          time_left_d  = TURN_MAX;
          redraw_d     = 1'b1;
        end
      end

      S_PLAY: begin
        if (move_valid && pos_in_range && (pos_cell == EMPTY)) begin
          // An accepted move beats a simultaneous timer expiry.
          wr_en  = 1'b1;
          wr_idx = move_pos;
        end else if (move_valid) begin
          // Refused request: the clock keeps ticking, no reload.
          reject_d = 1'b1;
          if (time_left_q != '0) time_left_d = time_left_q - TW'(1);
        end else if (time_left_q == '0) begin
          state_d = S_RANDOM;
          scan_d  = seed_idx;
        end else begin
          time_left_d = time_left_q - TW'(1);
        end
      end

      S_RANDOM: begin
        // A free cell always exists here: a full board leaves via CHECK.
        if (scan_cell == EMPTY) begin
          wr_en   = 1'b1;
          wr_idx  = scan_q;
          tmove_d = 1'b1;
        end else begin
          scan_d = scan_next;
        end
      end

      S_CHECK: begin
        if (win) begin
          state_d  = S_DONE;
          winner_d = cur_player_q ? W_O : W_X;
        end else if (count_q == CW'(NC)) begin
          state_d  = S_DONE;
          winner_d = W_TIE;
        end else begin
          state_d = S_SWITCH;
        end
      end

      S_SWITCH: begin
        cur_player_d = ~cur_player_q;
        time_left_d  = TURN_MAX;
        state_d      = S_PLAY;
      end

      default: state_d = S_IDLE;
    endcase

    if (wr_en) begin
      for (int i = 0; i < NC; i++) begin
        if (PW'(i) == wr_idx) board_d[2*i +: 2] = player_code;
      end
      count_d  = count_q + CW'(1);
      redraw_d = 1'b1;
      state_d  = S_CHECK;
    end
  end

  // State, board, timer, LFSR and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      board_q      <= '0;
      cur_player_q <= 1'b0;
      time_left_q  <= '0;
      winner_q     <= W_NONE;
      count_q      <= '0;
      scan_q       <= '0;
      lfsr_q       <= LFSR_SEED;
      reject_q     <= 1'b0;
      tmove_q      <= 1'b0;
      redraw_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      cur_player_q <= cur_player_d;
      time_left_q  <= time_left_d;
      winner_q     <= winner_d;
      count_q      <= count_d;
      scan_q       <= scan_d;
      lfsr_q       <= lfsr_d;
      reject_q     <= reject_d;
      tmove_q      <= tmove_d;
      redraw_q     <= redraw_d;
    end
  end

  assign move_ready   = (state_q == S_PLAY);
  assign game_over    = (state_q == S_DONE);
  assign move_reject  = reject_q;
  assign timeout_move = tmove_q;
  assign redraw       = redraw_q;
  assign cur_player   = cur_player_q;
  assign board        = board_q;
  assign time_left    = time_left_q;
  assign winner       = winner_q;
  assign dbg_state    = state_q;

endmodule
